// File: rtl/fb_port_arbiter_pkg.sv
// Shared types and constants for the frame-buffer port-A arbiter.
package fb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

endpackage

// File: rtl/fb_port_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear, tracking how long DMA has been losing.
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for frame-buffer port A with DMA starvation guard.
// Optional FB_ARB_VBLANK_LOCK_EN restricts DMA grants to vertical blanking.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 12
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wen,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic              vblank,
  output logic              fb_wena,
  output logic [ADDR_W-1:0] fb_addra,
  output logic [DATA_W-1:0] fb_dina,
  input  logic [DATA_W-1:0] fb_douta
);

  localparam int unsigned CNT_W = STARVE_CNT_W;

  arb_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_hit_c;
  logic              dma_ok_c;
  logic              cpu_gnt_c;
  logic              dma_gnt_c;
  logic              starve_inc_c;
  logic              starve_clr_c;

`ifdef FB_ARB_VBLANK_LOCK_EN
  assign dma_ok_c = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign dma_ok_c      = 1'b1;
`endif

  // Grants are gated by nreset so nothing reaches the memory while reset is held.
  always_comb begin
    starve_hit_c = (starve_cnt == CNT_W'(STARVE_LIMIT));
    dma_gnt_c    = nreset && dma_req && dma_ok_c && (!cpu_req || starve_hit_c);
    cpu_gnt_c    = nreset && cpu_req && !dma_gnt_c;
    starve_clr_c = dma_gnt_c || !dma_req;
    starve_inc_c = dma_req && !dma_gnt_c && dma_ok_c;
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clock  (clock),
    .nreset (nreset),
    .clr    (starve_clr_c),
    .inc    (starve_inc_c),
    .cnt    (starve_cnt)
  );

  // Next state records which requester owns the read data returning next cycle.
  always_comb begin
    state_d     = ARB_IDLE;
    rd_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    fb_wena     = 1'b0;
    fb_addra    = addr_q;
    fb_dina     = din_q;
    if (cpu_gnt_c) begin
      state_d  = ARB_CPU;
      rd_d     = !cpu_wen;
      addr_d   = cpu_addr;
      din_d    = cpu_wdata;
      fb_wena  = cpu_wen;
      fb_addra = cpu_addr;
      fb_dina  = cpu_wdata;
      if (!cpu_wen) begin
        cpu_rdata_d = fb_douta;
      end
    end else if (dma_gnt_c) begin
      state_d  = ARB_DMA;
      rd_d     = !dma_wen;
      addr_d   = dma_addr;
      din_d    = dma_wdata;
      fb_wena  = dma_wen;
      fb_addra = dma_addr;
      fb_dina  = dma_wdata;
      if (!dma_wen) begin
        dma_rdata_d = fb_douta;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ARB_IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_c;
  assign dma_gnt    = dma_gnt_c;
  assign cpu_rvalid = (state_q == ARB_CPU) && rd_q;
  assign dma_rvalid = (state_q == ARB_DMA) && rd_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized self-checking bench for fb_port_arbiter against a cycle-level reference model.
module tb_fb_port_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 12;

  logic          clock;
  logic          nreset;
  logic          cpu_req, cpu_wen, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_wen, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          vblank;
  logic          fb_wena;
  logic [AW-1:0] fb_addra;
  logic [DW-1:0] fb_dina, fb_douta;

  fb_port_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .ADDR_W       (AW),
    .DATA_W       (DW)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_wen    (dma_wen),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .vblank     (vblank),
    .fb_wena    (fb_wena),
    .fb_addra   (fb_addra),
    .fb_dina    (fb_dina),
    .fb_douta   (fb_douta)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: consecutive DMA losses, last driven address/data, pending read returns.
  int            losses;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          m_cpu_rv, m_dma_rv;
  logic [DW-1:0] m_cpu_rd, m_dma_rd;
  logic          last_ec, last_ed;
  int            n_dma_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    losses   = 0;
    m_addr   = '0;
    m_din    = '0;
    m_cpu_rv = 1'b0;
    m_dma_rv = 1'b0;
    m_cpu_rd = '0;
    m_dma_rd = '0;
    last_ec  = 1'b0;
    last_ed  = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic          ok, ec, ed, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] edin;
    #1;
    ok = 1'b1;
`ifdef FB_ARB_VBLANK_LOCK_EN
    ok = vblank;
`endif
    ed   = dma_req && ok && (!cpu_req || (losses == int'(LIMIT)));
    ec   = cpu_req && !ed;
    ea   = ec ? cpu_addr  : (ed ? dma_addr  : m_addr);
    edin = ec ? cpu_wdata : (ed ? dma_wdata : m_din);
    ew   = (ec && cpu_wen) || (ed && dma_wen);
    check_eq("cpu_gnt",    32'(cpu_gnt),    32'(ec));
    check_eq("dma_gnt",    32'(dma_gnt),    32'(ed));
    check_eq("fb_wena",    32'(fb_wena),    32'(ew));
    check_eq("fb_addra",   32'(fb_addra),   32'(ea));
    check_eq("fb_dina",    32'(fb_dina),    32'(edin));
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
    check_eq("dma_rvalid", 32'(dma_rvalid), 32'(m_dma_rv));
    check_eq("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rd));
    check_eq("dma_rdata",  32'(dma_rdata),  32'(m_dma_rd));
    @(posedge clock);
    m_addr   = ea;
    m_din    = edin;
    m_cpu_rv = ec && !cpu_wen;
    m_dma_rv = ed && !dma_wen;
    if (m_cpu_rv) m_cpu_rd = fb_douta;
    if (m_dma_rv) m_dma_rd = fb_douta;
    if (!dma_req || ed) losses = 0;
    else if (ok && losses < int'(LIMIT)) losses = losses + 1;
    last_ec = ec;
    last_ed = ed;
    if (ed) n_dma_gnt++;
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
    check_eq({tag, "_dma_gnt"},    32'(dma_gnt),    32'd0);
    check_eq({tag, "_fb_wena"},    32'(fb_wena),    32'd0);
    check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check_eq({tag, "_dma_rvalid"}, 32'(dma_rvalid), 32'd0);
    check_eq({tag, "_fb_addra"},   32'(fb_addra),   32'd0);
    check_eq({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'd0);
  endtask

  initial begin
    nreset    = 1'b0;
    cpu_req   = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req   = 1'b0; dma_wen = 1'b0; dma_addr = '0; dma_wdata = '0;
    vblank    = 1'b0;
    fb_douta  = '0;
    n_dma_gnt = 0;
    model_reset();

    // Reset state, including requests presented while reset is held.
    #2;
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 15'h1234;
    #1;
    check_reset_outputs("rst");
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0;
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;

    // Both idle after reset.
    step();

    // Lone CPU read: grant now, data next cycle.
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 15'h0010; fb_douta = 12'hABC;
    step();
    cpu_req = 1'b0; fb_douta = 12'h123;
    step();
    check_eq("cpu_read_data", 32'(cpu_rdata), 32'h0ABC);

    // Continuous contention: CPU x LIMIT, then DMA, repeating.
    vblank = 1'b1;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 15'h0100;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 15'h0200;
    n_dma_gnt = 0;
    for (int i = 0; i < 2 * (int'(LIMIT) + 1); i++) begin
      fb_douta = 12'($urandom);
      step();
    end
    check_eq("starve_dma_grants", 32'(n_dma_gnt), 32'd2);
    check_eq("starve_last_is_dma", 32'(last_ed), 32'd1);
    cpu_req = 1'b0; dma_req = 1'b0;
    step();

    // DMA write at the top of the address and data range.
    dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 15'h7FFF; dma_wdata = 12'hFFF;
    step();
    dma_req = 1'b0; dma_wen = 1'b0;
    step();

    // Reset asserted while a CPU read is returning.
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 15'h0042; fb_douta = 12'h5A5;
    step();
    cpu_req = 1'b0;
    nreset  = 1'b0;
    #1;
    check_reset_outputs("midrd");
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    step();

`ifdef FB_ARB_VBLANK_LOCK_EN
    // DMA held off outside blanking, granted once blanking starts.
    vblank = 1'b0; dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 15'h0333;
    n_dma_gnt = 0;
    for (int i = 0; i < 10; i++) step();
    check_eq("vblank_lock_hold", 32'(n_dma_gnt), 32'd0);
    vblank = 1'b1;
    step();
    check_eq("vblank_lock_release", 32'(last_ed), 32'd1);
    dma_req = 1'b0;
    step();
`endif

    // Randomized traffic; requesters keep req and payload stable until granted.
    for (int i = 0; i < 300; i++) begin
      if (!cpu_req || last_ec) begin
        cpu_req   = ($urandom % 3) != 0;
        cpu_wen   = 1'($urandom);
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
      end
      if (!dma_req || last_ed) begin
        dma_req   = ($urandom % 3) != 0;
        dma_wen   = 1'($urandom);
        dma_addr  = AW'($urandom);
        dma_wdata = DW'($urandom);
      end
      vblank   = ($urandom % 4) != 0;
      fb_douta = DW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
